sae_timing_ctrl: RTL

SAE_TIMING_CTRL -- requirements
Module: sae_timing_ctrl

---
 rtl/sae_timing_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sae_timing_ctrl.sv
// sae_timing_ctrl
// Launches a level into an external delay chain, waits for the returning
// sense-amp enable (SAE_RTN), captures sense-amp data on its arrival and
// measures the launch-to-return latency in clock cycles. Both the wait for
// the rising return and the wait for its release are bounded by TIMEOUT;
// an expiry sets a sticky error flag instead of producing data.
module sae_timing_ctrl #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 16,  // 2..255
    parameter int SYNC_STAGES = 2    // 2..4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_err_clr,
    input  logic              i_sae_rtn,
    input  logic [DATA_W-1:0] i_sa_dout,
    output logic              o_dly_in,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dvalid,
    output logic [7:0]        o_dly_cnt,
    output logic              o_busy,
    output logic              o_timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // 9 bits so cnt+1 never wraps before the compare
    localparam logic [8:0] TO_VAL = 9'(TIMEOUT);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     w_sae_s;
    logic [7:0]               r_cnt;
    logic [7:0]               w_cnt_nxt;
    logic [8:0]               w_cnt_inc;
    logic                     w_cnt_hit;
    logic                     r_dly_in;
    logic                     w_dly_in_nxt;
    logic                     r_dvalid;
    logic                     w_dvalid_nxt;
    logic [DATA_W-1:0]        r_dout;
    logic [DATA_W-1:0]        w_dout_nxt;
    logic [7:0]               r_dly_cnt;
    logic [7:0]               w_dly_cnt_nxt;
    logic                     r_err;
    logic                     w_err_nxt;

    // SAE_RTN is asynchronous to the clock; only the last stage is used
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_sae_rtn};
    end

    assign w_sae_s   = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
    assign w_cnt_hit = (w_cnt_inc == TO_VAL);

    // Next-state and next-register values; capture beats timeout in WAIT,
    // and a timeout beats a same-edge error clear
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_dly_in_nxt  = r_dly_in;
        w_dvalid_nxt  = 1'b0;
        w_dout_nxt    = r_dout;
        w_dly_cnt_nxt = r_dly_cnt;
        w_err_nxt     = r_err & ~i_err_clr;

        case (r_state)
            ST_IDLE: begin
                w_dly_in_nxt = 1'b0;
                // a still-high return from the previous read blocks relaunch
                if (i_req && !w_sae_s) begin
                    w_state_nxt  = ST_WAIT;
                    w_dly_in_nxt = 1'b1;
                    w_cnt_nxt    = 8'd0;
                end
            end
            ST_WAIT: begin
                if (w_sae_s) begin
                    w_state_nxt   = ST_RELEASE;
                    w_dout_nxt    = i_sa_dout;
                    w_dvalid_nxt  = 1'b1;
                    w_dly_cnt_nxt = w_cnt_inc[7:0];
                    w_dly_in_nxt  = 1'b0;
                    w_cnt_nxt     = 8'd0;
                end else if (w_cnt_hit) begin
                    w_state_nxt  = ST_RELEASE;
                    w_err_nxt    = 1'b1;
                    w_dly_in_nxt = 1'b0;
                    w_cnt_nxt    = 8'd0;
                end else begin
                    w_cnt_nxt    = w_cnt_inc[7:0];
                    w_dly_in_nxt = 1'b1;
                end
            end
            ST_RELEASE: begin
                w_dly_in_nxt = 1'b0;
                if (!w_sae_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc[7:0];
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_dly_in_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any read in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_dly_in  <= 1'b0;
            r_dvalid  <= 1'b0;
            r_dout    <= '0;
            r_dly_cnt <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dly_in  <= w_dly_in_nxt;
            r_dvalid  <= w_dvalid_nxt;
            r_dout    <= w_dout_nxt;
            r_dly_cnt <= w_dly_cnt_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign o_dly_in      = r_dly_in;
    assign o_dout        = r_dout;
    assign o_dvalid      = r_dvalid;
    assign o_dly_cnt     = r_dly_cnt;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_timeout_err = r_err;

endmodule
